booth_seq_ctrl: RTL and testbench

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

---
 rtl/booth_seq_ctrl_pkg.sv | 12 +
 rtl/booth_iter_step.sv | 45 ++++
 rtl/booth_seq_ctrl.sv | 113 +++++++++++
 tb/tb_booth_seq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_ctrl_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_seq_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_iter_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into acc, then an
// arithmetic right shift of {acc, Q, q_-1}.
module booth_iter_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH-1:0] addend;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             sign;

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    unique case ({q_i[0], qm1_i})
      2'b10: begin
        addend = ~m_i;
        cin    = 1'b1;
      end
      2'b01: addend = m_i;
      default: ;
    endcase
  end

  assign sum = acc_i + addend + WIDTH'(cin);

  // The wrapped sum stays in acc, but the bit shifted into the MSB must be the
  // sign of the true result, otherwise M = -2^(WIDTH-1) gives the wrong product.
  assign ovf  = (acc_i[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != acc_i[WIDTH-1]);
  assign sign = sum[WIDTH-1] ^ ovf;

  assign acc_o = {sign, sum[WIDTH-1:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential signed multiplier controller: valid/ready operand intake,
// WIDTH Booth iterations through one shared step, held product output.
//   state   | meaning
//   IDLE    | waiting for an operand pair, start_ready high
//   RUN     | one Booth iteration per cycle, busy high
//   DONE    | product valid, held until result_ready
module booth_seq_ctrl
  import booth_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]   q_n;
  logic               qm1_n;

  booth_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (acc_n),
    .q_o   (q_n),
    .qm1_o (qm1_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_n;
        q_d   = q_n;
        qm1_d = qm1_n;
        // Counter parks at LAST; the product is captured on the final step.
        if (cnt_q == LAST) begin
          prod_d  = {acc_n, q_n};
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q == ST_RUN);
  assign product      = prod_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed-vector and random-sample bench for booth_seq_ctrl at WIDTH=8.
module tb_booth_seq_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   multiplicand;
  logic           result_valid;
  logic           result_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int errors = 0;
  int checks = 0;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   q;
    logic [W-1:0]   m;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation with result_ready high; inputs are scrambled after the
  // accepting edge to confirm operands are only sampled there.
  task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] m,
                       input logic [2*W-1:0] exp, input string name, input bit full);
    int lat;
    result_ready = 1'b1;
    start_valid  = 1'b1;
    multiplier   = q;
    multiplicand = m;
    if (full) chk({name, " start_ready"}, 32'(start_ready), 32'd1);
    tick();
    start_valid  = 1'b0;
    multiplier   = ~q;
    multiplicand = ~m;
    if (full) chk({name, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (full) chk({name, " latency"}, 32'(lat), 32'(W));
    chk({name, " product"}, 32'(product), 32'(exp));
    tick();
    if (full) begin
      chk({name, " back idle"}, 32'(start_ready), 32'd1);
      chk({name, " product kept"}, 32'(product), 32'(exp));
    end
  endtask

  initial begin
    logic [W-1:0]   rq, rm;
    logic [2*W-1:0] held;
    int             qi, mi, lat;
    bit             seen;

    vecs[0] = '{8'd3,  8'd5,  16'd15};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h80, 8'h7F, 16'hC080};
    vecs[3] = '{8'h00, 8'hFF, 16'h0000};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[6] = '{8'h7F, 8'h80, 16'hC080};
    vecs[7] = '{8'hFF, 8'h01, 16'hFFFF};
    vecs[8] = '{8'h80, 8'h01, 16'hFF80};
    vecs[9] = '{8'h55, 8'hF6, 16'hFCAE};

    rst          = 1'b1;
    start_valid  = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    result_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset start_ready", 32'(start_ready), 32'd1);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset product", 32'(product), 32'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].q, vecs[i].m, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);

    // Stall in DONE with a stray start pulse.
    result_ready = 1'b0;
    start_valid  = 1'b1;
    multiplier   = 8'd9;
    multiplicand = 8'd11;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("stall latency", 32'(lat), 32'(W));
    chk("stall product", 32'(product), 32'd99);
    for (int i = 0; i < 5; i++) begin
      start_valid  = (i == 2);
      multiplier   = 8'd2;
      multiplicand = 8'd2;
      tick();
      chk("stall hold product", 32'(product), 32'd99);
      chk("stall hold valid", 32'(result_valid), 32'd1);
      chk("stall start_ready", 32'(start_ready), 32'd0);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    tick();
    chk("stall release idle", 32'(start_ready), 32'd1);
    tick();
    chk("stall no queued op", 32'(busy), 32'd0);

    // Reset in the middle of RUN.
    start_valid  = 1'b1;
    multiplier   = 8'd100;
    multiplicand = 8'd50;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrun busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun rst idle", 32'(start_ready), 32'd1);
    chk("midrun rst busy", 32'(busy), 32'd0);
    chk("midrun rst product", 32'(product), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid) seen = 1'b1;
    end
    chk("midrun no result", 32'(seen), 32'd0);
    do_op(8'd7, 8'hFA, 16'hFFD6, "after rst 7x-6", 1'b1);

    // Random sample of the operand space against a signed reference.
    for (int i = 0; i < 1500; i++) begin
      rq = W'($urandom);
      rm = W'($urandom);
      qi = int'($signed(rq));
      mi = int'($signed(rm));
      held = 16'(qi * mi);
      do_op(rq, rm, held, $sformatf("rand q=%0d m=%0d", qi, mi), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
